// File: rtl/muldiv_pkg.sv
// muldiv_pkg
//   Shared definitions for the iterative multiply/divide unit.
//   - md_state_e : 3-bit FSM encoding (IDLE=1, MULT=2, DIV=3, DONE=4). The
//                  values are fixed because they are exported on the debug
//                  state port when MULDIV_STATE_OUT_EN is defined.
//   - MD_OP_MULT / MD_OP_DIV : encodings of the op input.
package muldiv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd1,
    ST_MULT = 3'd2,
    ST_DIV  = 3'd3,
    ST_DONE = 3'd4
  } md_state_e;

  localparam logic MD_OP_MULT = 1'b0;
  localparam logic MD_OP_DIV  = 1'b1;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step
//   Combinational single-iteration datapath shared by multiply and divide.
//   Ports:
//     op      in   MD_OP_MULT: radix-2 Booth step; MD_OP_DIV: restoring step
//     acc_in  in   WIDTH+1  partial product high part / partial remainder
//     q_in    in   WIDTH    multiplier bits being consumed / dividend-quotient
//     qm1_in  in   1        Booth "previous multiplier bit" (unused for div)
//     m_in    in   WIDTH+1  sign-extended multiplicand / zero-extended divisor
//     acc_out, q_out, qm1_out  out  state after this iteration
//   The accumulator carries one extra bit so that subtracting the
//   most-negative multiplicand (and the restoring trial subtract) never
//   overflows.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             op,
  input  logic [WIDTH:0]   acc_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic             qm1_in,
  input  logic [WIDTH:0]   m_in,
  output logic [WIDTH:0]   acc_out,
  output logic [WIDTH-1:0] q_out,
  output logic             qm1_out
);

  logic [WIDTH:0] booth_sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    // Booth recoding: 01 -> +M, 10 -> -M, 00/11 -> no add.
    booth_sum = acc_in;
    case ({q_in[0], qm1_in})
      2'b01:   booth_sum = acc_in + m_in;
      2'b10:   booth_sum = acc_in - m_in;
      default: booth_sum = acc_in;
    endcase

    // Restoring division: shift the next dividend bit into the remainder
    // and try to subtract the divisor; a negative trial keeps the shift.
    shifted = {acc_in[WIDTH-1:0], q_in[WIDTH-1]};
    trial   = shifted - m_in;

    acc_out = acc_in;
    q_out   = q_in;
    qm1_out = 1'b0;

    if (op == MD_OP_MULT) begin
      // Arithmetic shift right of {acc, q, qm1}.
      acc_out = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
      q_out   = {booth_sum[0], q_in[WIDTH-1:1]};
      qm1_out = q_in[0];
    end else if (!trial[WIDTH]) begin
      acc_out = trial;
      q_out   = {q_in[WIDTH-2:0], 1'b1};
    end else begin
      acc_out = shifted;
      q_out   = {q_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Self-timed iterative signed multiply/divide unit producing HI/LO.
//   start is sampled only in IDLE; the unit then runs WIDTH iterations
//   (busy high), spends one cycle in DONE (done pulse, hi/lo valid) and
//   returns to IDLE. Divide by zero goes straight to DONE with div_zero set
//   and leaves hi/lo untouched.
//   Ports:
//     clock, reset        clock and asynchronous active-high reset
//     start, op, a, b     request, op (0 mult / 1 div), operands
//     busy, done          iterating flag, single-cycle completion pulse
//     div_zero            pulse coincident with done on divide by zero
//     hi, lo              mult: product halves; div: remainder / quotient
//   Optional debug ports (macro MULDIV_STATE_OUT_EN):
//     state_out [2:0]     registered FSM encoding
//     iter_out [CNT_W-1:0] current iteration count
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef MULDIV_STATE_OUT_EN
  ,
  output logic [2:0]       state_out,
  output logic [CNT_W-1:0] iter_out
`endif
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] qr_q, qr_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH:0]   m_q, m_d;
  logic             a_neg_q, a_neg_d;   // remainder takes dividend sign
  logic             q_neg_q, q_neg_d;   // quotient negative when signs differ
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;

  logic             step_op;
  logic [WIDTH:0]   step_acc;
  logic [WIDTH-1:0] step_q;
  logic             step_qm1;
  logic [WIDTH-1:0] step_rem;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    // Most-negative maps to itself, which is the correct unsigned magnitude.
    return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
  endfunction

  assign step_op  = (state_q == ST_DIV) ? MD_OP_DIV : MD_OP_MULT;
  assign step_rem = step_acc[WIDTH-1:0];

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op      (step_op),
    .acc_in  (acc_q),
    .q_in    (qr_q),
    .qm1_in  (qm1_q),
    .m_in    (m_q),
    .acc_out (step_acc),
    .q_out   (step_q),
    .qm1_out (step_qm1)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    qr_d       = qr_q;
    qm1_d      = qm1_q;
    m_d        = m_q;
    a_neg_d    = a_neg_q;
    q_neg_d    = q_neg_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    div_zero_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d = '0;
          acc_d = '0;
          qm1_d = 1'b0;
          if (op == MD_OP_MULT) begin
            state_d = ST_MULT;
            qr_d    = b;
            m_d     = {a[WIDTH-1], a};
            busy_d  = 1'b1;
          end else if (b != '0) begin
            state_d = ST_DIV;
            qr_d    = mag(a);
            m_d     = {1'b0, mag(b)};
            a_neg_d = a[WIDTH-1];
            q_neg_d = a[WIDTH-1] ^ b[WIDTH-1];
            busy_d  = 1'b1;
          end else begin
            state_d    = ST_DONE;
            done_d     = 1'b1;
            div_zero_d = 1'b1;
          end
        end
      end

      ST_MULT, ST_DIV: begin
        acc_d = step_acc;
        qr_d  = step_q;
        qm1_d = step_qm1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          // Results are taken straight from the final step so they are
          // valid in the DONE cycle itself.
          state_d = ST_DONE;
          done_d  = 1'b1;
          cnt_d   = '0;
          if (state_q == ST_MULT) begin
            hi_d = step_rem;
            lo_d = step_q;
          end else begin
            hi_d = a_neg_q ? (~step_rem + WIDTH'(1)) : step_rem;
            lo_d = q_neg_q ? (~step_q + WIDTH'(1)) : step_q;
          end
        end else begin
          busy_d = 1'b1;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      qr_q       <= '0;
      qm1_q      <= 1'b0;
      m_q        <= '0;
      a_neg_q    <= 1'b0;
      q_neg_q    <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      qr_q       <= qr_d;
      qm1_q      <= qm1_d;
      m_q        <= m_d;
      a_neg_q    <= a_neg_d;
      q_neg_q    <= q_neg_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

`ifdef MULDIV_STATE_OUT_EN
  assign state_out = state_q;
  assign iter_out  = cnt_q;
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clock;
  logic         reset;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_assert = 0;
  int n_fail   = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation (start high in cycle 0), then watch 60 cycles.
  // Operands are scrambled from cycle 1 on. If intr != 0, a div request is
  // pulsed in cycle intr and must be ignored.
  task automatic run_op(input string tag, input logic o, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input int exp_cyc,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                        input logic exp_dz, input int intr);
    int got_cyc;
    int pulses;
    int bad;
    logic [W-1:0] got_hi;
    logic [W-1:0] got_lo;
    logic got_dz;
    got_cyc = -1;
    pulses  = 0;
    bad     = 0;
    got_hi  = '0;
    got_lo  = '0;
    got_dz  = 1'b0;
    @(negedge clock);
    start = 1'b1; op = o; a = av; b = bv;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clock);
      if (c == 1) begin
        start = 1'b0; op = ~o; a = $urandom; b = $urandom | 32'h1;
      end
      if (intr != 0 && c == intr) begin
        start = 1'b1; op = 1'b1;
      end
      if (intr != 0 && c == intr + 1) start = 1'b0;
      if (c < exp_cyc && (busy !== 1'b1 || done !== 1'b0)) bad++;
      if (c >= exp_cyc && busy !== 1'b0) bad++;
      if (done === 1'b1) begin
        pulses++;
        if (got_cyc < 0) begin
          got_cyc = c; got_hi = hi; got_lo = lo; got_dz = div_zero;
        end
      end else if (div_zero !== 1'b0) begin
        bad++;
      end
    end
    chk({tag, "/done_cycle"}, 64'(got_cyc), 64'(exp_cyc));
    chk({tag, "/done_pulses"}, 64'(pulses), 64'd1);
    chk({tag, "/busy_profile_errors"}, 64'(bad), 64'd0);
    chk({tag, "/hi"}, 64'(got_hi), 64'(exp_hi));
    chk({tag, "/lo"}, 64'(got_lo), 64'(exp_lo));
    chk({tag, "/div_zero"}, 64'(got_dz), 64'(exp_dz));
    $display("op %s: cycle=%0d hi=0x%08h lo=0x%08h dz=%0b", tag, got_cyc, got_hi, got_lo, got_dz);
  endtask

  initial begin
    int pulses;
    int bad;
    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clock);
    chk("reset/busy", 64'(busy), 64'd0);
    chk("reset/done", 64'(done), 64'd0);
    chk("reset/div_zero", 64'(div_zero), 64'd0);
    chk("reset/hi", 64'(hi), 64'd0);
    chk("reset/lo", 64'(lo), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    run_op("mult_7_x_m3",    1'b0, 32'd7,        32'hFFFFFFFD, W+1, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 0);
    run_op("mult_min_x_min", 1'b0, 32'h80000000, 32'h80000000, W+1, 32'h40000000, 32'h00000000, 1'b0, 0);
    run_op("mult_m5_x_m6",   1'b0, 32'hFFFFFFFB, 32'hFFFFFFFA, W+1, 32'h00000000, 32'h0000001E, 1'b0, 0);
    run_op("mult_max_x_max", 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, W+1, 32'h3FFFFFFF, 32'h00000001, 1'b0, 0);
    run_op("div_m7_by_2",    1'b1, 32'hFFFFFFF9, 32'd2,        W+1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0);
    run_op("div_7_by_m2",    1'b1, 32'd7,        32'hFFFFFFFE, W+1, 32'h00000001, 32'hFFFFFFFD, 1'b0, 0);
    run_op("div_100_by_7",   1'b1, 32'd100,      32'd7,        W+1, 32'd2,        32'd14,       1'b0, 0);
    run_op("div_3_by_5",     1'b1, 32'd3,        32'd5,        W+1, 32'd3,        32'd0,        1'b0, 0);
    run_op("div_min_by_m1",  1'b1, 32'h80000000, 32'hFFFFFFFF, W+1, 32'h00000000, 32'h80000000, 1'b0, 0);
    run_op("div_5_by_0",     1'b1, 32'd5,        32'd0,        1,   32'h00000000, 32'h80000000, 1'b1, 0);
    run_op("mult_3x4_intr",  1'b0, 32'd3,        32'd4,        W+1, 32'd0,        32'd12,       1'b0, 10);

    // Reset in cycle 15 of a multiply: abort, clear results, no done pulse.
    @(negedge clock);
    start = 1'b1; op = 1'b0; a = 32'd9; b = 32'd9;
    @(negedge clock);
    start = 1'b0;
    repeat (14) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midreset/busy", 64'(busy), 64'd0);
    chk("midreset/done", 64'(done), 64'd0);
    chk("midreset/hi", 64'(hi), 64'd0);
    chk("midreset/lo", 64'(lo), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    pulses = 0;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (done === 1'b1) pulses++;
      if (busy !== 1'b0) bad++;
    end
    chk("midreset/late_done_pulses", 64'(pulses), 64'd0);
    chk("midreset/late_busy", 64'(bad), 64'd0);
    $display("op midreset: done_pulses=%0d busy_errors=%0d", pulses, bad);

    run_op("mult_after_reset", 1'b0, 32'h12345678, 32'h10, W+1, 32'h00000001, 32'h23456780, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative signed multiply/divide unit for the multicycle MIPS core, producing HI/LO results.
- Owns its own sequencing FSM, so the main control unit only issues start and waits for done. It does not step each iteration.
- Sits beside the ALU and shifter. HI/LO feed the MemToReg mux (mfhi/mflo) and div_zero feeds the exception/EPC path.
- Replaces the fixed-width, control-driven sequencing with a parametrised, self-timed block.

Parameters:
- WIDTH, 32, operand width in bits (>=4). HI and LO are each WIDTH bits.
- CNT_W, $clog2(WIDTH+1), iteration counter width (localparam, derived).

Ports:
- clock  in  1  system clock
- reset  in  1  reset
- start  in  1  request operation; sampled only in IDLE
- op  in  1  0 = mult, 1 = div (both signed)
- a  in  WIDTH  multiplicand / dividend
- b  in  WIDTH  multiplier / divisor
- busy  out  1  high while iterating
- done  out  1  single-cycle completion pulse
- div_zero  out  1  single-cycle pulse, coincident with done, on divide by zero
- hi  out  WIDTH  mult: upper product half; div: remainder
- lo  out  WIDTH  mult: lower product half; div: quotient
- Interface: reset reset, asynchronous, active-high; clock clock.

Behaviour:
- Reset values: FSM returns to IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0, counter=0.
- States:
  - IDLE: start=1 latches a, b, op.
    - op=0 -> MULT.
    - op=1 and b!=0 -> DIV.
    - op=1 and b==0 -> DONE with the divide-by-zero flag set.
  - MULT: radix-2 Booth, one step per cycle, WIDTH cycles.
  - DIV: restoring division on magnitudes, WIDTH cycles; signs are fixed up on exit.
  - DONE: one cycle, then IDLE.
- Timing, with start high in cycle 0 (IDLE):
  - busy=1 in cycles 1..WIDTH.
  - DONE occupies cycle WIDTH+1: done=1, busy=0.
  - hi/lo are updated at the edge entering DONE and are therefore valid in that cycle.
  - Divide by zero: DONE in cycle 1, done=1, div_zero=1, hi/lo unchanged.
- Back-to-back: a new start is accepted in the IDLE cycle after DONE. Minimum issue interval is WIDTH+2 cycles.
- start while busy or in DONE: ignored, no queuing. a/b/op changes after cycle 0 have no effect.
- Multiply result: the full 2*WIDTH signed product; never overflows.
- Divide result:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Most-negative / -1: lo = most-negative (wraps), hi = 0, no flag.
- hi/lo hold their values until the next completed non-zero-divide operation.
- Reset mid-operation: aborts immediately; no done pulse; hi/lo are cleared.
- Outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: MULDIV_STATE_OUT_EN.
- Defined:
  - Adds output state_out [2:0], carrying the registered FSM encoding (IDLE=1, MULT=2, DIV=3, DONE=4).
  - Adds output iter_out [CNT_W-1:0], carrying the current iteration count.
  - Both are used for debug and waveform tracing.
- Undefined: neither port exists; behaviour is otherwise identical.

Decomposition:
- Package muldiv_pkg:
  - FSM state enum (3-bit, values above).
  - op encodings MD_OP_MULT=0 and MD_OP_DIV=1.
- Sub-module: muldiv_step, a combinational single-iteration datapath.
  - Performs the Booth add/sub/shift or the restoring subtract/shift, selected by op.
  - The FSM, counter and sign fix-up stay in muldiv_unit.

Test Plan (WIDTH=32):
- mult a=7, b=-3 (0xFFFFFFFD) -> done in cycle 33, hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy high in cycles 1..32.
- mult a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000.
- div a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; then div a=5, b=0 -> done and div_zero in cycle 1, hi/lo unchanged.
- Issue mult 3*4; pulse start with op=1 in cycle 10 (busy) -> ignored; result hi=0, lo=12; no second done pulse.
- Start mult, assert reset in cycle 15 -> busy=0, hi=lo=0, FSM in IDLE, no done pulse; a fresh start afterwards completes normally.
